// File: rtl/mgmt_storage_arbiter.sv
// Wishbone plus read-only requester sharing BANKS single-port SRAM blocks under round-robin arbitration.
// Optional macro STORAGE_ARB_WB_ERR_EN: an out-of-range WB bank answers with wb_err_o instead of wb_ack_o.
module mgmt_storage_arbiter #(
    parameter int BANKS  = 2,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1,
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                     core_clk,
    input  logic                     core_rstn,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [3:0]               wb_sel_i,
    input  logic [31:0]              wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    output logic                     wb_ack_o,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_err_o,
    input  logic                     ro_req_i,
    input  logic [BANK_W+ADDR_W-1:0] ro_addr_i,
    output logic                     ro_gnt_o,
    output logic                     ro_valid_o,
    output logic [31:0]              ro_rdata_o,
    output logic [BANKS-1:0]         mem_ena_o,
    output logic [BANKS-1:0]         mem_wen_o,
    output logic [BANKS*4-1:0]       mem_wen_mask_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic [BANKS*32-1:0]      mem_rdata_i
);

`ifdef STORAGE_ARB_WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              last_ro, cur_ro, cur_we, cur_oor, wb_lost, err_q;
    logic [BANK_W-1:0] cur_bank;
    logic [1:0]        wait_cnt;

    logic              wb_req, pick_ro, sel_oor, wb_gone;
    logic [BANK_W-1:0] wb_bank, ro_bank, sel_bank;
    logic [ADDR_W-1:0] sel_word;
    logic [BANKS-1:0]  sel_hot;
    logic [BANKS*4-1:0] sel_mask;
    logic [31:0]       rd_slice;

    wire unused_adr = &{1'b0, wb_adr_i[31:ADDR_W+BANK_W+2], wb_adr_i[1:0]};

    assign wb_req   = wb_cyc_i & wb_stb_i;
    assign wb_bank  = wb_adr_i[ADDR_W+BANK_W+1:ADDR_W+2];
    assign ro_bank  = ro_addr_i[BANK_W+ADDR_W-1:ADDR_W];
    // last_ro set means RO had the previous grant, so a contending WB wins
    assign pick_ro  = ro_req_i & (~wb_req | ~last_ro);
    assign sel_bank = pick_ro ? ro_bank : wb_bank;
    assign sel_word = pick_ro ? ro_addr_i[ADDR_W-1:0] : wb_adr_i[ADDR_W+1:2];
    assign sel_oor  = int'(sel_bank) >= BANKS;
    assign wb_gone  = wb_lost | ~wb_cyc_i;
    assign wb_err_o = err_q;

    // An out-of-range bank matches no slot: no enable, and read data falls back to 0
    always_comb begin
        sel_hot  = '0;
        sel_mask = '0;
        rd_slice = '0;
        for (int b = 0; b < BANKS; b++) begin
            sel_hot[b] = (sel_bank == BANK_W'(b));
            sel_mask[b*4 +: 4] = sel_hot[b] ? wb_sel_i : 4'b0;
            if (cur_bank == BANK_W'(b))
                rd_slice = mem_rdata_i[b*32 +: 32];
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            state          <= IDLE;
            last_ro        <= 1'b1;
            cur_ro         <= 1'b0;
            cur_we         <= 1'b0;
            cur_oor        <= 1'b0;
            wb_lost        <= 1'b0;
            err_q          <= 1'b0;
            cur_bank       <= '0;
            wait_cnt       <= '0;
            wb_ack_o       <= 1'b0;
            wb_dat_o       <= '0;
            ro_gnt_o       <= 1'b0;
            ro_valid_o     <= 1'b0;
            ro_rdata_o     <= '0;
            mem_ena_o      <= '0;
            mem_wen_o      <= '0;
            mem_wen_mask_o <= '0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
        end else begin
            wb_ack_o       <= 1'b0;
            err_q          <= 1'b0;
            ro_gnt_o       <= 1'b0;
            ro_valid_o     <= 1'b0;
            mem_ena_o      <= '0;
            mem_wen_o      <= '0;
            mem_wen_mask_o <= '0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            if (state != IDLE && !cur_ro && !wb_cyc_i)
                wb_lost <= 1'b1;

            case (state)
                IDLE: begin
                    if (wb_req || ro_req_i) begin
                        state      <= ISSUE;
                        wb_lost    <= 1'b0;
                        cur_ro     <= pick_ro;
                        last_ro    <= pick_ro;
                        cur_bank   <= sel_bank;
                        cur_we     <= !pick_ro && wb_we_i;
                        cur_oor    <= sel_oor;
                        ro_gnt_o   <= pick_ro;
                        mem_addr_o <= sel_word;
                        mem_ena_o  <= sel_hot;
                        if (!pick_ro && wb_we_i) begin
                            mem_wen_o      <= sel_hot;
                            mem_wen_mask_o <= sel_mask;
                            mem_wdata_o    <= wb_dat_i;
                        end
                    end
                end
                ISSUE: begin
                    if (cur_we || (!cur_ro && cur_oor)) begin
                        state <= RESP;
                        if (!wb_gone) begin
                            if (cur_oor && ERR_EN)
                                err_q <= 1'b1;
                            else
                                wb_ack_o <= 1'b1;
                        end
                        if (cur_oor && !cur_we && !ERR_EN)
                            wb_dat_o <= '0;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 2'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt != 2'd0) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end else begin
                        state <= RESP;
                        if (cur_ro) begin
                            ro_valid_o <= 1'b1;
                            ro_rdata_o <= rd_slice;
                        end else begin
                            wb_dat_o <= rd_slice;
                            wb_ack_o <= !wb_gone;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mgmt_storage_arbiter.sv
// Directed bench for mgmt_storage_arbiter with BANKS=3, RD_LAT=3 and a behavioural banked SRAM model.
module tb_mgmt_storage_arbiter;
    localparam int BANKS  = 3;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 3;
    localparam int BANK_W = 2;

    logic                     core_clk = 1'b0;
    logic                     core_rstn;
    logic                     wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]               wb_sel_i;
    logic [31:0]              wb_adr_i, wb_dat_i;
    logic                     wb_ack_o, wb_err_o;
    logic [31:0]              wb_dat_o;
    logic                     ro_req_i;
    logic [BANK_W+ADDR_W-1:0] ro_addr_i;
    logic                     ro_gnt_o, ro_valid_o;
    logic [31:0]              ro_rdata_o;
    logic [BANKS-1:0]         mem_ena_o, mem_wen_o;
    logic [BANKS*4-1:0]       mem_wen_mask_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [31:0]              mem_wdata_o;
    logic [BANKS*32-1:0]      mem_rdata_i;

    mgmt_storage_arbiter #(.BANKS(BANKS), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .core_clk(core_clk), .core_rstn(core_rstn),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
        .wb_err_o(wb_err_o), .ro_req_i(ro_req_i), .ro_addr_i(ro_addr_i), .ro_gnt_o(ro_gnt_o),
        .ro_valid_o(ro_valid_o), .ro_rdata_o(ro_rdata_o), .mem_ena_o(mem_ena_o),
        .mem_wen_o(mem_wen_o), .mem_wen_mask_o(mem_wen_mask_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 core_clk = ~core_clk;

    // SRAM model: data is valid RD_LAT cycles after the enable cycle, garbage otherwise
    logic [31:0]         store [BANKS][256];
    logic [BANKS*32-1:0] rd_pipe [RD_LAT];
    always @(posedge core_clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (mem_ena_o[b] && mem_wen_o[b])
                for (int k = 0; k < 4; k++)
                    if (mem_wen_mask_o[b*4+k])
                        store[b][mem_addr_o][k*8 +: 8] <= mem_wdata_o[k*8 +: 8];
            rd_pipe[0][b*32 +: 32] <= (mem_ena_o[b] && !mem_wen_o[b]) ? store[b][mem_addr_o] : 32'hDEAD_0000;
        end
        for (int s = 1; s < RD_LAT; s++)
            rd_pipe[s] <= rd_pipe[s-1];
    end
    assign mem_rdata_i = rd_pipe[RD_LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{wb_ack_o, wb_dat_o, wb_err_o, ro_gnt_o, ro_valid_o, ro_rdata_o,
                 mem_ena_o, mem_wen_o, mem_wen_mask_o, mem_addr_o, mem_wdata_o};
    endfunction

    // Per-cycle history of one transaction; bit c = seen in cycle c after the accepting edge
    logic [15:0]        ack_hist, err_hist, gnt_hist, val_hist;
    logic [BANKS-1:0]   ena_c1, wen_c1, ena_other;
    logic [BANKS*4-1:0] mask_c1;
    logic [ADDR_W-1:0]  addr_c1;
    logic [31:0]        wdata_c1, dat_seen, ro_seen;

    task automatic wb_start(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w; wb_sel_i = s; wb_adr_i = a; wb_dat_i = d;
    endtask

    task automatic observe(input int n, input int drop_at);
        ack_hist = '0; err_hist = '0; gnt_hist = '0; val_hist = '0; ena_other = '0;
        dat_seen = 32'hFFFF_FFFF; ro_seen = 32'hFFFF_FFFF;
        @(posedge core_clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge core_clk);
            ack_hist[c] = wb_ack_o;
            err_hist[c] = wb_err_o;
            gnt_hist[c] = ro_gnt_o;
            val_hist[c] = ro_valid_o;
            if (c == 1) begin
                ena_c1 = mem_ena_o; wen_c1 = mem_wen_o; mask_c1 = mem_wen_mask_o;
                addr_c1 = mem_addr_o; wdata_c1 = mem_wdata_o;
            end else begin
                ena_other = ena_other | mem_ena_o;
            end
            if (wb_ack_o) dat_seen = wb_dat_o;
            if (ro_valid_o) ro_seen = ro_rdata_o;
            if (wb_ack_o || wb_err_o || c == drop_at) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
            end
            if (ro_gnt_o) ro_req_i = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc;
        core_rstn = 1'b0;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = '0; wb_adr_i = '0; wb_dat_i = '0;
        ro_req_i = 0; ro_addr_i = '0;
        repeat (3) @(negedge core_clk);
        check("reset_outs", any_out(), 0);
        core_rstn = 1'b1;

        // Masked write over a fully written word, then readback through the RO port
        wb_start(1'b1, 4'hF, 32'h414, 32'h1122_3344);
        observe(4, 0);
        check("wfull_ack", ack_hist, 16'h0004);
        wb_start(1'b1, 4'b0011, 32'h414, 32'hDEAD_BEEF);
        observe(4, 0);
        check("w_ena", ena_c1, 3'b010);
        check("w_wen", wen_c1, 3'b010);
        check("w_mask", mask_c1, 12'h030);
        check("w_addr", addr_c1, 8'd5);
        check("w_wdata", wdata_c1, 32'hDEAD_BEEF);
        check("w_ack", ack_hist, 16'h0004);
        check("w_mem_idle", ena_other, 3'b000);
        ro_req_i = 1'b1; ro_addr_i = 10'h105;
        observe(6, 0);
        check("ro_gnt", gnt_hist, 16'h0002);
        check("ro_valid", val_hist, 16'h0020);
        check("ro_data", ro_seen, 32'h1122_BEEF);
        check("ro_ena", ena_c1, 3'b010);
        check("ro_noack", ack_hist, 16'h0000);

        // WB read with RD_LAT=3: ack in cycle 5
        wb_start(1'b1, 4'hF, 32'h008, 32'h1234_5678);
        observe(4, 0);
        wb_start(1'b1, 4'hF, 32'h40C, 32'hCAFE_F00D);
        observe(4, 0);
        wb_start(1'b0, 4'hF, 32'h008, 32'h0);
        observe(6, 0);
        check("r_ena", ena_c1, 3'b001);
        check("r_wen", wen_c1, 3'b000);
        check("r_ack", ack_hist, 16'h0020);
        check("r_data", dat_seen, 32'h1234_5678);

        // Simultaneous requests after reset: WB first, RO accepted at the following IDLE
        core_rstn = 1'b0;
        @(negedge core_clk);
        core_rstn = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            wb_start(1'b0, 4'hF, 32'h008, 32'h0);
            ro_req_i = 1'b1; ro_addr_i = 10'h103;
            observe(12, 0);
            check($sformatf("arb%0d_wb_ack", rep), ack_hist, 16'h0020);
            check($sformatf("arb%0d_ro_gnt", rep), gnt_hist, 16'h0080);
            check($sformatf("arb%0d_ro_valid", rep), val_hist, 16'h0800);
            check($sformatf("arb%0d_wb_data", rep), dat_seen, 32'h1234_5678);
            check($sformatf("arb%0d_ro_data", rep), ro_seen, 32'hCAFE_F00D);
        end

        // Out-of-range bank 3
        wb_start(1'b0, 4'hF, 32'hC00, 32'h0);
        observe(3, 0);
        check("oor_ena", ena_c1, 3'b000);
        check("oor_ena_later", ena_other, 3'b000);
`ifdef STORAGE_ARB_WB_ERR_EN
        check("oor_err", err_hist, 16'h0004);
        check("oor_noack", ack_hist, 16'h0000);
        check("oor_dat_held", wb_dat_o, 32'h1234_5678);
`else
        check("oor_ack", ack_hist, 16'h0004);
        check("oor_noerr", err_hist, 16'h0000);
        check("oor_data", dat_seen, 32'h0);
`endif
        ro_req_i = 1'b1; ro_addr_i = 10'h300;
        observe(6, 0);
        check("ro_oor_gnt", gnt_hist, 16'h0002);
        check("ro_oor_valid", val_hist, 16'h0020);
        check("ro_oor_data", ro_seen, 32'h0);
        check("ro_oor_ena", ena_c1, 3'b000);

        // cyc dropped in cycle 1: access completes without ack, FSM free again by cycle 6
        wb_start(1'b0, 4'hF, 32'h008, 32'h0);
        observe(6, 1);
        check("drop_noack", ack_hist, 16'h0000);
        check("drop_ena", ena_c1, 3'b001);
        wb_start(1'b1, 4'hF, 32'h010, 32'h0BAD_CAFE);
        observe(4, 0);
        check("drop_next_ack", ack_hist, 16'h0004);

        // Reset in cycle 2 of a read kills the response
        wb_start(1'b0, 4'hF, 32'h008, 32'h0);
        @(posedge core_clk);
        @(negedge core_clk);
        @(negedge core_clk);
        core_rstn = 1'b0;
        @(negedge core_clk);
        check("rst_mid_outs", any_out(), 0);
        core_rstn = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        acc = 1'b0;
        repeat (8) begin
            @(negedge core_clk);
            acc = acc | wb_ack_o | ro_valid_o;
        end
        check("rst_mid_noresp", acc, 0);
        wb_start(1'b0, 4'hF, 32'h008, 32'h0);
        observe(6, 0);
        check("rst_next_ack", ack_hist, 16'h0020);
        check("rst_next_data", dat_seen, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mgmt_storage_arbiter.md
Name: mgmt_storage_arbiter

Overview:
Parametrised bridge between the management Wishbone bus and a multi-bank single-port SRAM storage array (BANKS blocks of 2^ADDR_W x 32-bit words, byte write masks).
Adds a second read-only requester port (debug or housekeeping readback) that shares the banks with the Wishbone port under round-robin arbitration.
Supports configurable SRAM read latency.
Sits between mgmt_core and the storage macro, replacing the fixed-width direct mgmt_ena/mgmt_wen/mgmt_addr hookup.

Parameters:
BANKS, 2, number of SRAM blocks (1..8); BANK_W = max(1, clog2(BANKS)) is a localparam
ADDR_W, 8, word address width per bank
RD_LAT, 1, SRAM read latency in cycles from enable cycle to valid mem_rdata_i (1..4)

Ports:
core_clk  in  1  clock
core_rstn  in  1  synchronous active-low reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  strobe, pre-qualified by upstream address decode
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte selects
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_ack_o  out  1  acknowledge
wb_dat_o  out  32  read data
wb_err_o  out  1  error, meaningful only with macro
ro_req_i  in  1  RO read request, held until ro_gnt_o
ro_addr_i  in  BANK_W+ADDR_W  {bank, word} address
ro_gnt_o  out  1  request accepted
ro_valid_o  out  1  read data valid
ro_rdata_o  out  32  read data
mem_ena_o  out  BANKS  per-bank enable
mem_wen_o  out  BANKS  per-bank write enable
mem_wen_mask_o  out  BANKS*4  per-bank byte mask
mem_addr_o  out  ADDR_W  shared word address
mem_wdata_o  out  32  shared write data
mem_rdata_i  in  BANKS*32  per-bank read data

Behaviour:
- Synchronous active-low reset on core_rstn. Reset clears all outputs to 0, puts the FSM in IDLE and sets last_grant = RO.
- Reset mid-operation drops the in-flight access; no ack or valid is issued for it.
- Decode: WB word = wb_adr_i[ADDR_W+1:2], WB bank = wb_adr_i[ADDR_W+BANK_W+1:ADDR_W+2]. RO bank/word are taken from ro_addr_i MSBs/LSBs.
- A bank index >= BANKS is out of range.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE, WB request present (wb_cyc_i & wb_stb_i): sampled at edge 0.
- IDLE, both requesters pending: the one not equal to last_grant wins, and last_grant updates to the winner.
- ISSUE (cycle 1): registered mem_ena_o one-hot for the target bank.
  - Write: mem_wen_o bit set and mem_wen_mask_o[4b+3:4b] = wb_sel_i.
  - Unselected banks see all-zero enable, wen and mask.
  - mem_addr_o and mem_wdata_o are driven.
  - ro_gnt_o pulses high this cycle if RO won.
  - Out of range: no enable bits are set.
- Write path: ISSUE -> RESP. wb_ack_o is high in cycle 2 for exactly one cycle.
- Read path: ISSUE -> WAIT for RD_LAT-1 cycles. The selected bank's 32-bit slice is captured at the end of cycle 1+RD_LAT.
  - RESP is cycle 2+RD_LAT: wb_ack_o with wb_dat_o, or ro_valid_o with ro_rdata_o, for one cycle.
  - wb_dat_o and ro_rdata_o hold their value until the next capture.
- RESP -> IDLE unconditionally. In classic Wishbone the master drops stb the cycle after ack, so there is no re-acceptance.
- Throughput: one access in flight. Writes take 3 cycles per access; reads take 3+RD_LAT.
- If wb_cyc_i drops before RESP, the memory access still completes but wb_ack_o is suppressed.
- RO out-of-range: ro_valid_o returns with data 0.
- WB out-of-range without the macro: ack with data 0; the write is dropped.
- mem_* outputs return to 0 in every state except ISSUE.

Optional Feature:
STORAGE_ARB_WB_ERR_EN.
- Defined: a WB access to an out-of-range bank raises wb_err_o for one cycle in cycle 2 instead of wb_ack_o. There is no memory access, and wb_dat_o is unchanged.
- Undefined: wb_err_o is tied 0 and out-of-range handling is ack with data 0.
- The RO port behaviour is identical either way.

Test Plan:
1. BANKS=2, RD_LAT=1. WB write 0xDEADBEEF to adr 0x414 (bank1, word 5) with sel 4'b0011.
   - Required in cycle 1: mem_ena_o=2'b10, mem_wen_o=2'b10, mem_wen_mask_o=8'b0011_0000, mem_addr_o=5.
   - Required: wb_ack_o in cycle 2 only.
2. RD_LAT=2. WB read adr 0x008 with the bank0 model returning 0x12345678.
   - Required: mem_ena_o=2'b01 in cycle 1 and wb_ack_o in cycle 4 with wb_dat_o=0x12345678.
3. After reset, WB read and RO read (ro_addr_i={1,8'h03}) both asserted in the same cycle.
   - Required: WB is served first and RO is granted at the following IDLE with ro_gnt_o in its ISSUE cycle.
   - Required: a repeat of the simultaneous request grants WB again, since last_grant = RO.
4. BANKS=3. WB read bank index 3.
   - Without the macro: ack in cycle 2 with data 0 and no mem_ena_o bit set.
   - With STORAGE_ARB_WB_ERR_EN: wb_err_o=1 in cycle 2 and wb_ack_o stays 0.
5. RD_LAT=3 read, with core_rstn low in cycle 2.
   - Required: no wb_ack_o afterward and all outputs 0.
   - Required: the next read after reset completes normally at cycle 5.
6. WB read with wb_cyc_i dropped in cycle 1 -> no wb_ack_o; FSM back in IDLE by cycle 4 (RD_LAT=1) and accepts a new request.
